// File: rtl/mult_pingpong_sched_if.sv
// mult_pingpong_sched_if: requester operand bus and result stream for the
// ping-pong multiplier scheduler. The scheduler uses the slave modport; the
// requesters and the result consumer use the master modport.
interface mult_pingpong_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 15
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*DW-1:0] req_a;
  logic [NUM_REQ*DW-1:0] req_b;
  logic                  res_valid;
  logic                  res_ready;
  logic [2*DW-1:0]       res_data;
  logic [ID_W-1:0]       res_id;
  logic                  busy;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_id, busy
  );
endinterface

// File: rtl/mult_pingpong_sched.sv
// mult_pingpong_sched: round-robin arbiter feeding two registered DWxDW
// multiplier lanes in alternating (ping-pong) phase. Results return in
// acceptance order through a credit-protected FIFO, tagged with requester ID.
// Optional macro MULT_PINGPONG_SCHED_STATS_EN adds saturating issue/stall
// counters on the stat_issue / stat_stall ports.

// Overflow and grant-shape checks, kept outside the functional logic.
module mult_pingpong_sched_chk #(
  parameter int NUM_REQ = 4
) (
  input logic               clk,
  input logic               rst_n,
  input logic               push,
  input logic               full,
  input logic [NUM_REQ-1:0] grant
);
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
  a_grant_onehot0:     assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
endmodule

module mult_pingpong_sched #(
  parameter int NUM_REQ   = 4,
  parameter int DW        = 15,
  parameter int RES_DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  mult_pingpong_sched_if.slave bus
`ifdef MULT_PINGPONG_SCHED_STATS_EN
  ,
  output logic [15:0] stat_issue,
  output logic [15:0] stat_stall
`endif
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int PW   = 2 * DW;
  localparam int AW   = $clog2(RES_DEPTH);
  localparam int CW   = AW + 1;

  typedef enum logic {PH_LANE0 = 1'b0, PH_LANE1 = 1'b1} phase_e;

  phase_e            phase_r, phase_nxt_s;
  logic [ID_W-1:0]   rr_ptr_r;
  logic [NUM_REQ-1:0] grant_s;
  logic [ID_W-1:0]   grant_idx_s;
  logic [DW-1:0]     grant_a_s, grant_b_s;
  logic              found_s;
  logic [ID_W:0]     cand_s;
  logic              accept_s;
  logic [1:0]        load_s;

  // Lane stage 1 holds operands, stage 2 holds the product awaiting push.
  logic [1:0]        v1_r, v2_r;
  logic [DW-1:0]     a_r [2];
  logic [DW-1:0]     b_r [2];
  logic [ID_W-1:0]   id1_r [2];
  logic [PW-1:0]     p_r [2];
  logic [ID_W-1:0]   id2_r [2];

  logic              push_s, pop_s, full_s, credit_s;
  logic [PW-1:0]     push_data_s;
  logic [ID_W-1:0]   push_id_s;
  logic [1:0]        inflight_s;
  logic [CW:0]       occupancy_s;
  logic [PW-1:0]     mem_r [RES_DEPTH];
  logic [ID_W-1:0]   mem_id_r [RES_DEPTH];
  logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]     count_r;

  // Phase state register: lane target alternates every cycle out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_r <= PH_LANE0;
    else        phase_r <= phase_nxt_s;
  end

  // Phase next-state: unconditional toggle.
  always_comb begin
    phase_nxt_s = PH_LANE0;
    case (phase_r)
      PH_LANE0: phase_nxt_s = PH_LANE1;
      PH_LANE1: phase_nxt_s = PH_LANE0;
      default:  phase_nxt_s = PH_LANE0;
    endcase
  end

  // Phase outputs: route an accepted request into the lane owned by this phase.
  always_comb begin
    load_s = 2'b00;
    case (phase_r)
      PH_LANE0: load_s = {1'b0, accept_s};
      PH_LANE1: load_s = {accept_s, 1'b0};
      default:  load_s = 2'b00;
    endcase
  end

  // Credit: lanes in flight and queued results must leave room in the FIFO.
  always_comb begin
    inflight_s  = {1'b0, v1_r[0] | v2_r[0]} + {1'b0, v1_r[1] | v2_r[1]};
    occupancy_s = (CW+1)'(count_r) + (CW+1)'(inflight_s);
    credit_s    = occupancy_s < (CW+1)'(RES_DEPTH);
  end

  // Round-robin search from rr_ptr; grant depends only on registered state
  // and req_valid, never on res_ready.
  always_comb begin
    found_s     = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    grant_s     = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand_s = {1'b0, rr_ptr_r} + (ID_W+1)'(off);
      if (cand_s >= (ID_W+1)'(NUM_REQ)) cand_s = cand_s - (ID_W+1)'(NUM_REQ);
      else                              cand_s = cand_s;
      if (!found_s && bus.req_valid[cand_s[ID_W-1:0]]) begin
        found_s     = 1'b1;
        grant_idx_s = cand_s[ID_W-1:0];
      end else begin
      end
    end
    if (found_s && credit_s && rst_n) grant_s[grant_idx_s] = 1'b1;
    else                              grant_s = '0;
  end

  // Operand mux for the granted requester.
  always_comb begin
    grant_a_s = '0;
    grant_b_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx_s == ID_W'(i)) begin
        grant_a_s = bus.req_a[i*DW +: DW];
        grant_b_s = bus.req_b[i*DW +: DW];
      end else begin
      end
    end
  end

  assign accept_s      = |(grant_s & bus.req_valid);
  assign bus.req_ready = grant_s;

  // Round-robin pointer moves past the accepted requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      rr_ptr_r <= '0;
    else if (accept_s && grant_idx_s == ID_W'(NUM_REQ-1)) rr_ptr_r <= '0;
    else if (accept_s)                               rr_ptr_r <= grant_idx_s + ID_W'(1);
    else                                             rr_ptr_r <= rr_ptr_r;
  end

  // Lane pipeline: capture operands, then register the full-width product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r <= 2'b00;
      v2_r <= 2'b00;
      for (int l = 0; l < 2; l++) begin
        a_r[l]   <= '0;
        b_r[l]   <= '0;
        id1_r[l] <= '0;
        p_r[l]   <= '0;
        id2_r[l] <= '0;
      end
    end else begin
      for (int l = 0; l < 2; l++) begin
        v1_r[l] <= load_s[l];
        v2_r[l] <= v1_r[l];
        if (load_s[l]) begin
          a_r[l]   <= grant_a_s;
          b_r[l]   <= grant_b_s;
          id1_r[l] <= grant_idx_s;
        end
        if (v1_r[l]) begin
          p_r[l]   <= {{DW{1'b0}}, a_r[l]} * {{DW{1'b0}}, b_r[l]};
          id2_r[l] <= id1_r[l];
        end
      end
    end
  end

  // Push select: lanes finish on alternate edges, so at most one is ready.
  always_comb begin
    push_s = v2_r[0] | v2_r[1];
    if (v2_r[0]) begin
      push_data_s = p_r[0];
      push_id_s   = id2_r[0];
    end else begin
      push_data_s = p_r[1];
      push_id_s   = id2_r[1];
    end
  end

  assign pop_s  = (count_r != '0) && bus.res_ready;
  assign full_s = (count_r == CW'(RES_DEPTH));

  // Result FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int e = 0; e < RES_DEPTH; e++) begin
        mem_r[e]    <= '0;
        mem_id_r[e] <= '0;
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r]    <= push_data_s;
        mem_id_r[wr_ptr_r] <= push_id_s;
        wr_ptr_r           <= wr_ptr_r + AW'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign bus.res_valid = (count_r != '0);
  assign bus.res_data  = mem_r[rd_ptr_r];
  assign bus.res_id    = mem_id_r[rd_ptr_r];
  assign bus.busy      = (count_r != '0) | (|v1_r) | (|v2_r);

`ifdef MULT_PINGPONG_SCHED_STATS_EN
  // Saturating counters of accepted requests and cycles stalled with demand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issue <= 16'h0000;
      stat_stall <= 16'h0000;
    end else begin
      if (accept_s && stat_issue != 16'hFFFF) stat_issue <= stat_issue + 16'h0001;
      else                                     stat_issue <= stat_issue;
      if ((|bus.req_valid) && !accept_s && stat_stall != 16'hFFFF) stat_stall <= stat_stall + 16'h0001;
      else                                                          stat_stall <= stat_stall;
    end
  end
`else
`endif

  mult_pingpong_sched_chk #(.NUM_REQ(NUM_REQ)) u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .full  (full_s),
    .grant (grant_s)
  );
endmodule

// File: tb/tb_mult_pingpong_sched.sv
// Directed self-checking bench for mult_pingpong_sched (NUM_REQ=4, DW=15,
// RES_DEPTH=4). Inputs change and outputs are sampled on the falling edge.
module tb_mult_pingpong_sched;
  localparam int NUM_REQ = 4;
  localparam int DW = 15;
  localparam int RES_DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [29:0] prod [4];

  mult_pingpong_sched_if #(.NUM_REQ(NUM_REQ), .DW(DW)) bus ();

`ifdef MULT_PINGPONG_SCHED_STATS_EN
  logic [15:0] stat_issue, stat_stall;
`endif

  mult_pingpong_sched #(.NUM_REQ(NUM_REQ), .DW(DW), .RES_DEPTH(RES_DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef MULT_PINGPONG_SCHED_STATS_EN
    ,
    .stat_issue (stat_issue),
    .stat_stall (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    prod[0] = 30'd200;
    prod[1] = 30'd2100;
    prod[2] = 30'd65534;
    prod[3] = 30'd1000000;
    bus.req_valid = 4'b0000;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_res_data",  64'(bus.res_data),  64'd0);
    check("rst_res_id",    64'(bus.res_id),    64'd0);
    check("rst_busy",      64'(bus.busy),      64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    rst_n = 1'b1;
    check("phase_rel", 64'(dut.phase_r), 64'd0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      check("phase_toggle", 64'(dut.phase_r), 64'(c % 2));
      check("idle_ready",   64'(bus.req_ready), 64'd0);
    end

    // Single request from requester 2, max operands
    bus.req_a = {15'd0, 15'h7FFF, 15'd0, 15'd0};
    bus.req_b = {15'd0, 15'h7FFF, 15'd0, 15'd0};
    bus.req_valid = 4'b0100;
    #1;
    check("single_ready", 64'(bus.req_ready), 64'h4);
    tick();
    bus.req_valid = 4'b0000;
    check("single_k_valid", 64'(bus.res_valid), 64'd0);
    check("single_k_busy",  64'(bus.busy),      64'd1);
    tick();
    check("single_k1_valid", 64'(bus.res_valid), 64'd0);
    tick();
    check("single_k2_valid", 64'(bus.res_valid), 64'd1);
    check("single_data",     64'(bus.res_data),  64'h3FFF0001);
    check("single_id",       64'(bus.res_id),    64'd2);
    bus.res_ready = 1'b1;
    tick();
    check("single_pop_valid", 64'(bus.res_valid), 64'd0);
    check("single_pop_busy",  64'(bus.busy),      64'd0);

    // Fresh reset so arbitration restarts at requester 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // Round-robin streaming with res_ready high
    bus.req_a = {15'd1000, 15'd32767, 15'd300, 15'd10};
    bus.req_b = {15'd1000, 15'd2,     15'd7,   15'd20};
    bus.req_valid = 4'b1111;
    bus.res_ready = 1'b1;
    #1;
    check("rr_ready_first", 64'(bus.req_ready), 64'h1);
    for (int j = 1; j <= 12; j++) begin
      tick();
      check("rr_ready", 64'(bus.req_ready), 64'(4'b0001 << (j % 4)));
      if (j >= 3) begin
        check("rr_valid", 64'(bus.res_valid), 64'd1);
        check("rr_id",    64'(bus.res_id),    64'((j - 3) % 4));
        check("rr_data",  64'(bus.res_data),  64'(prod[(j - 3) % 4]));
      end else begin
        check("rr_latency", 64'(bus.res_valid), 64'd0);
      end
    end
    bus.req_valid = 4'b0000;
    tick();
    check("rr_drain_id2", 64'(bus.res_id),   64'd2);
    check("rr_drain_d2",  64'(bus.res_data), 64'(prod[2]));
    tick();
    check("rr_drain_id3", 64'(bus.res_id),   64'd3);
    tick();
    check("rr_drain_valid", 64'(bus.res_valid), 64'd0);
    check("rr_drain_busy",  64'(bus.busy),      64'd0);

    // Backpressure: exactly RES_DEPTH acceptances, then stall
    bus.res_ready = 1'b0;
    bus.req_valid = 4'b1111;
    #1;
    check("bp_ready0", 64'(bus.req_ready), 64'h1);
    tick(); check("bp_ready1", 64'(bus.req_ready), 64'h2);
    tick(); check("bp_ready2", 64'(bus.req_ready), 64'h4);
    tick(); check("bp_ready3", 64'(bus.req_ready), 64'h8);
    for (int k = 4; k <= 8; k++) begin
      tick();
      check("bp_stall_ready", 64'(bus.req_ready), 64'd0);
      check("bp_stall_valid", 64'(bus.res_valid), 64'd1);
      check("bp_stable_id",   64'(bus.res_id),    64'd0);
      check("bp_stable_data", 64'(bus.res_data),  64'(prod[0]));
    end
    bus.res_ready = 1'b1;
    tick(); check("bp_m1_id", 64'(bus.res_id), 64'd1); check("bp_m1_ready", 64'(bus.req_ready), 64'h1);
    check("bp_m1_data", 64'(bus.res_data), 64'(prod[1]));
    tick(); check("bp_m2_id", 64'(bus.res_id), 64'd2); check("bp_m2_ready", 64'(bus.req_ready), 64'h2);
    tick(); check("bp_m3_id", 64'(bus.res_id), 64'd3); check("bp_m3_ready", 64'(bus.req_ready), 64'h4);
    tick(); check("bp_m4_id", 64'(bus.res_id), 64'd0); check("bp_m4_ready", 64'(bus.req_ready), 64'h8);
    bus.req_valid = 4'b0000;
    tick(); check("bp_m5_id", 64'(bus.res_id), 64'd1);
    tick(); check("bp_m6_id", 64'(bus.res_id), 64'd2);
    tick(); check("bp_m7_valid", 64'(bus.res_valid), 64'd0);
    check("bp_m7_busy", 64'(bus.busy), 64'd0);

    // Reset with lanes in flight and results queued
    bus.res_ready = 1'b0;
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) tick();
    check("mid_pre_valid", 64'(bus.res_valid), 64'd1);
    check("mid_pre_busy",  64'(bus.busy),      64'd1);
    check("mid_pre_id",    64'(bus.res_id),    64'd3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.res_valid), 64'd0);
    check("mid_rst_busy",  64'(bus.busy),      64'd0);
    check("mid_rst_ready", 64'(bus.req_ready), 64'd0);
    check("mid_rst_data",  64'(bus.res_data),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid = 4'b0010;
    #1;
    check("mid_new_ready", 64'(bus.req_ready), 64'h2);
    tick();
    bus.req_valid = 4'b0000;
    tick();
    check("mid_new_lat", 64'(bus.res_valid), 64'd0);
    tick();
    check("mid_new_valid", 64'(bus.res_valid), 64'd1);
    check("mid_new_id",    64'(bus.res_id),    64'd1);
    check("mid_new_data",  64'(bus.res_data),  64'(prod[1]));
    bus.res_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("mid_only_one", 64'(bus.res_valid), 64'd0);
    end
    check("mid_end_busy", 64'(bus.busy), 64'd0);

`ifdef MULT_PINGPONG_SCHED_STATS_EN
    // Statistics: 10 accepts, 6 stalled cycles, then saturation
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("stat_rst_issue", 64'(stat_issue), 64'd0);
    check("stat_rst_stall", 64'(stat_stall), 64'd0);
    bus.res_ready = 1'b0;
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 10; k++) tick();
    check("stat_issue4", 64'(stat_issue), 64'd4);
    check("stat_stall6", 64'(stat_stall), 64'd6);
    bus.req_valid = 4'b0000;
    bus.res_ready = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) tick();
    bus.req_valid = 4'b0000;
    check("stat_issue10", 64'(stat_issue), 64'd10);
    check("stat_stall_hold", 64'(stat_stall), 64'd6);
    for (int k = 0; k < 6; k++) tick();
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 70000; k++) tick();
    check("stat_issue_sat", 64'(stat_issue), 64'hFFFF);
    check("stat_stall_end", 64'(stat_stall), 64'd6);
    bus.req_valid = 4'b0000;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
